// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register: valid/ready handshake backed by a 2-entry skid buffer, with synchronous flush.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN; the default build omits the port and logic.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_skid: DATA_W and CNT_W must be >= 1");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occ_q, occ_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next state and payload movement; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags and occupancy are decoded from the next state so they leave the stage as flops.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        case (state_d)
            ST_BUSY: occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of back-pressured cycles; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
